if_id_stage: RTL and testbench

IF/ID pipeline register with integrated load-use hazard detection for the 5-stage 64-bit RISC-V pipeline. It sits directly downstream of the instruction fetch stage: it captures the fetched `pc`/`instruction` each cycle and presents them to decode. It generates `PC_write` back to fetch and a bubble request to ID/EX on a load-use hazard, and squashes its contents on a taken branch.

---
 rtl/if_id_stage.sv | 94 +++++++++
 tb/tb_if_id_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and branch flush.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [63:0] PC_RESET  = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        branch_taken,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    output logic [63:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic        PC_write,
    output logic        idex_bubble
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       hazard;

    // Decide which source register fields the held instruction actually reads.
    always_comb begin
        opcode   = id_instruction[6:0];
        rs1      = id_instruction[19:15];
        rs2      = id_instruction[24:20];
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
                uses_rs1 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
        hazard = id_valid & idex_mem_read & (idex_rd != 5'd0) &
                 ((uses_rs1 & (rs1 == idex_rd)) | (uses_rs2 & (rs2 == idex_rd)));
    end

    // A flush wins over a stall, so the fetch PC keeps moving on a taken branch.
    always_comb begin
        PC_write    = 1'b1;
        idex_bubble = 1'b0;
        if (!rst) begin
            PC_write    = ~(hazard & ~branch_taken);
            idex_bubble = hazard | branch_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            id_pc          <= PC_RESET;
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (!hazard) begin
            id_pc          <= if_pc;
            id_instruction <= if_instruction;
            id_valid       <= 1'b1;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    // Saturating event counters; stall only counts when no flush is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (branch_taken && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
            if (!branch_taken && hazard && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed literal checks plus a
// randomized phase compared every cycle against a behavioural model.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;
    logic        branch_taken;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        PC_write;
    logic        idex_bubble;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    if_id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .branch_taken   (branch_taken),
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .PC_write       (PC_write),
        .idex_bubble    (idex_bubble)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_count    (stall_count),
        .flush_count    (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: what decode should be holding right now.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_known = 0;
    longint      m_stalls = 0;
    longint      m_flushes = 0;

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011,
                          7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit model_hazard();
        bit m1;
        bit m2;
        m1 = reads_rs1(m_instr[6:0]) && (m_instr[19:15] == idex_rd);
        m2 = reads_rs2(m_instr[6:0]) && (m_instr[24:20] == idex_rd);
        return m_valid && idex_mem_read && (idex_rd != 5'd0) && (m1 || m2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 64'h0; m_instr = 32'h13; m_valid = 0; m_known = 1;
            m_stalls = 0; m_flushes = 0;
        end else if (branch_taken) begin
            m_pc = 64'h0; m_instr = 32'h13; m_valid = 0;
            if (m_flushes < 64'hFFFF_FFFF) m_flushes++;
        end else if (m_known && model_hazard()) begin
            if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
        end else begin
            m_pc = if_pc; m_instr = if_instruction; m_valid = 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit h;
        if (m_known) begin
            checkOutput("model id_pc", id_pc, m_pc);
            checkOutput("model id_instruction", {32'h0, id_instruction}, {32'h0, m_instr});
            checkOutput("model id_valid", {63'h0, id_valid}, {63'h0, m_valid});
`ifdef IF_ID_PERF_CNT_EN
            checkOutput("model stall_count", {32'h0, stall_count}, 64'(m_stalls));
            checkOutput("model flush_count", {32'h0, flush_count}, 64'(m_flushes));
`endif
            h = rst ? 1'b0 : model_hazard();
            checkOutput("model PC_write", {63'h0, PC_write},
                        {63'h0, (rst ? 1'b1 : !(h && !branch_taken))});
            checkOutput("model idex_bubble", {63'h0, idex_bubble},
                        {63'h0, (rst ? 1'b0 : (h || branch_taken))});
        end
    end

    task automatic applyStimulus(input logic r, input logic [63:0] pc, input logic [31:0] instr,
                                 input logic bt, input logic mr, input logic [4:0] rd);
        @(posedge clk);
        #2;
        rst = r; if_pc = pc; if_instruction = instr;
        branch_taken = bt; idex_mem_read = mr; idex_rd = rd;
    endtask

    logic [6:0] opcodes [10] = '{7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011,
                                  7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111,
                                  7'b0110111, 7'b1101111};

    initial begin
        rst = 1'b1; if_pc = 64'h10; if_instruction = 32'h00A28293;
        branch_taken = 1'b0; idex_mem_read = 1'b0; idex_rd = 5'd0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset id_pc", id_pc, 64'h0);
        checkOutput("reset id_instruction", {32'h0, id_instruction}, 64'h13);
        checkOutput("reset id_valid", {63'h0, id_valid}, 64'h0);
        checkOutput("reset PC_write", {63'h0, PC_write}, 64'h1);
        checkOutput("reset idex_bubble", {63'h0, idex_bubble}, 64'h0);

        applyStimulus(0, 64'h14, 32'h00B50633, 0, 0, 5'd0);
        @(negedge clk);
        checkOutput("pass id_pc", id_pc, 64'h10);
        checkOutput("pass id_instruction", {32'h0, id_instruction}, 64'h00A28293);
        checkOutput("pass id_valid", {63'h0, id_valid}, 64'h1);

        applyStimulus(0, 64'h18, 32'h00000013, 0, 1, 5'd10);
        @(negedge clk);
        checkOutput("loaduse PC_write", {63'h0, PC_write}, 64'h0);
        checkOutput("loaduse idex_bubble", {63'h0, idex_bubble}, 64'h1);

        applyStimulus(0, 64'h1C, 32'h000122B7, 0, 0, 5'd0);
        @(negedge clk);
        checkOutput("stall hold id_pc", id_pc, 64'h14);
        checkOutput("stall hold id_instruction", {32'h0, id_instruction}, 64'h00B50633);

        applyStimulus(0, 64'h20, 32'h00B00633, 0, 1, 5'd2);
        @(negedge clk);
        checkOutput("resume id_pc", id_pc, 64'h1C);
        checkOutput("lui no stall PC_write", {63'h0, PC_write}, 64'h1);

        applyStimulus(0, 64'h24, 32'h00B50633, 0, 1, 5'd0);
        @(negedge clk);
        checkOutput("x0 no stall PC_write", {63'h0, PC_write}, 64'h1);
        checkOutput("x0 no stall idex_bubble", {63'h0, idex_bubble}, 64'h0);

        applyStimulus(0, 64'h28, 32'h00A28293, 1, 1, 5'd11);
        @(negedge clk);
        checkOutput("flush+hazard PC_write", {63'h0, PC_write}, 64'h1);
        checkOutput("flush+hazard idex_bubble", {63'h0, idex_bubble}, 64'h1);

        applyStimulus(0, 64'h2C, 32'h00A28293, 0, 0, 5'd0);
        @(negedge clk);
        checkOutput("flush id_valid", {63'h0, id_valid}, 64'h0);
        checkOutput("flush id_instruction", {32'h0, id_instruction}, 64'h13);
        checkOutput("flush id_pc", id_pc, 64'h0);

        // Three stalls and two flushes from a clean reset.
        applyStimulus(1, 64'h40, 32'h00B50633, 0, 0, 5'd0);
        applyStimulus(0, 64'h40, 32'h00B50633, 0, 0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 64'h40, 32'h00B50633, 0, 1, 5'd10);
            applyStimulus(0, 64'h40, 32'h00B50633, 0, 0, 5'd0);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 64'h40, 32'h00B50633, 1, 0, 5'd0);
            applyStimulus(0, 64'h40, 32'h00B50633, 0, 0, 5'd0);
        end
        @(negedge clk);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("stall_count 3", {32'h0, stall_count}, 64'd3);
        checkOutput("flush_count 2", {32'h0, flush_count}, 64'd2);
        applyStimulus(1, 64'h40, 32'h00B50633, 0, 0, 5'd0);
        applyStimulus(0, 64'h40, 32'h00B50633, 0, 0, 5'd0);
        @(negedge clk);
        checkOutput("stall_count cleared", {32'h0, stall_count}, 64'd0);
        checkOutput("flush_count cleared", {32'h0, flush_count}, 64'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [31:0] instr;
            instr = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     3'($urandom), 5'($urandom), opcodes[$urandom_range(0, 9)]};
            applyStimulus(($urandom_range(0, 49) == 0), {$urandom, $urandom}, instr,
                          ($urandom_range(0, 7) == 0), 1'($urandom),
                          5'($urandom_range(0, 3)));
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
